mode_manager: RTL and testbench
===============================

// Module: mode_manager
// PURPOSE
//  Parametrised top-level mode sequencer. Starts in HELLO mode and wakes to ACTIVE on any user activity.
//  Cycles through NUM_MODES display/LED sources. Blanks the display for a short window on each mode change.
//  Falls back to HELLO after an idle timeout.
//  Sits between the debounce stage and the display/LED drivers; sub-blocks see one-hot enables.
// PARAMETERS
//  NUM_MODES     4     total modes incl. mode 0 = HELLO (>=2)
//  NUM_SW        7     debounced switch inputs watched for activity
//  NUM_BTN       4     debounced button inputs watched for activity
//  DISP_W        20    width of one display source word
//  LED_W         8     width of one LED source word
//  IDLE_TIMEOUT  2**26 idle cycles before return to HELLO; 0 disables
//  BLANK_CYCLES  4     display-blank cycles after a mode change (>=1)
//  BLANK_CODE    '1    disp value driven while blanking (DISP_W bits)
// PORTS
//  clk        in   1                  system clock, all logic on rising edge
//  rst        in   1                  synchronous, active-high reset
//  sw         in   NUM_SW             debounced switch levels
//  btn        in   NUM_BTN            debounced button levels
//  mode_btn   in   1                  debounced level; rising edge = advance mode
//  disp_in    in   NUM_MODES*DISP_W   source m at [m*DISP_W +: DISP_W]
//  led_in     in   NUM_MODES*LED_W    source m at [m*LED_W +: LED_W]
//  mode       out  clog2(NUM_MODES)   current mode index
//  en         out  NUM_MODES          one-hot enable, en[mode]
//  mode_chg   out  1                  1-cycle pulse when mode changes
//  disp       out  DISP_W             registered display word
//  led        out  LED_W              registered LED word
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=HELLO, mode=0, en=1, mode_chg=0, disp=0, led=0, idle_cnt=0, blank_cnt=0.
//  Sample registers load the current sw/btn/mode_btn during reset, so the first cycle after reset reports no activity.
//  Activity (act) = any sw bit toggled, OR any btn rising edge, OR mode_btn rising edge.
//  Edge detection compares against the 1-cycle-delayed sample.
//  States:
//   HELLO : mode=0. act -> BLANK, mode<=1, mode_chg=1. Exactly one step, even if the act was mode_btn.
//   BLANK : blank_cnt counts BLANK_CYCLES, then -> ACTIVE. mode_btn edges are ignored for advancing but count as act.
//   ACTIVE: mode_btn edge -> mode<=mode+1; wrap from NUM_MODES-1 to 1 (never to 0); mode_chg=1; -> BLANK.
//  Idle: idle_cnt clears on act, otherwise increments, saturating at IDLE_TIMEOUT. It is frozen at 0 in HELLO.
//  In ACTIVE or BLANK with idle_cnt==IDLE_TIMEOUT-1 and no act this cycle: -> HELLO, mode<=0, mode_chg=1.
//  In that case blank_cnt is cleared.
//  Simultaneous act and timeout in the same cycle: act wins, no timeout.
//  Outputs are registered with 1-cycle latency from the mode register.
//   disp = BLANK_CODE while the next state is BLANK, else disp_in[mode].
//   led = led_in[mode] always.
//  en always equals onehot(mode), updated in the same cycle as mode. mode_chg is high exactly 1 cycle per change.
//  rst asserted mid-operation (e.g. during BLANK) forces the reset values on the next edge, with no residual pulse.
// STRUCTURE
//  mode_manager_pkg: state encoding (HELLO=0, BLANK=1, ACTIVE=2) and a clog2 function.
//  Sub-module activity_detect: sw/btn/mode_btn sample registers, act and mode_edge outputs, saturating idle_cnt, timeout flag.
//  Top level: FSM, mode register, blank counter, output muxes.
// TESTING
//  1 Reset, hold all inputs static for 100 cycles -> mode=0, en=4'b0001, no mode_chg, disp=disp_in[0].
//  2 In HELLO, btn[2] rises -> next cycle mode=1, mode_chg=1, disp=BLANK_CODE for 4 cycles, then disp_in[1].
//  3 In ACTIVE with mode=3 and NUM_MODES=4, mode_btn edge -> mode=1 (skips 0), en=4'b0010.
//  4 Reduce IDLE_TIMEOUT to 16 and stay idle -> mode=0 exactly 16 cycles after the last act.
//    Variant: sw[0] toggles on cycle 15 -> no return to HELLO.
//  5 Two mode_btn edges 2 cycles apart during BLANK -> no extra advance, idle_cnt cleared.
//  6 rst pulse during BLANK with sw differing from its pre-reset value -> reset values, then no act on the first post-reset cycle.

Source files
------------

// File: rtl/mode_manager_pkg.sv
// Shared state encoding and width helper for the mode sequencer.
// Pure declarations: no latency, no backpressure.
package mode_manager_pkg;

    typedef enum logic [1:0] {
        HELLO  = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // Bits needed to index `value` entries; never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/mode_manager_activity_detect.sv
// Input sampling, activity/mode-edge detection and saturating idle counter with timeout flag.
// act/mode_edge/timeout are combinational from the 1-cycle-delayed samples; no backpressure.
module mode_manager_activity_detect
    import mode_manager_pkg::*;
#(
    parameter int NUM_SW       = 7,
    parameter int NUM_BTN      = 4,
    parameter int IDLE_TIMEOUT = 2**26
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic               mode_btn_i,
    input  logic               hold_i,
    output logic               act_o,
    output logic               mode_edge_o,
    output logic               timeout_o
);

    localparam int IDLE_W = clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [NUM_SW-1:0]  sw_q;
    logic [NUM_BTN-1:0] btn_q;
    logic               mode_btn_q;
    logic [IDLE_W-1:0]  idle_cnt_q;
    logic [IDLE_W-1:0]  idle_cnt_d;

    // Samples load even under reset so the first post-reset cycle sees no edges.
    always_ff @(posedge clk_i) begin
        sw_q       <= sw_i;
        btn_q      <= btn_i;
        mode_btn_q <= mode_btn_i;
        if (rst_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign mode_edge_o = mode_btn_i & ~mode_btn_q;
    assign act_o       = (|(sw_i ^ sw_q)) | (|(btn_i & ~btn_q)) | mode_edge_o;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (hold_i || act_o) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
    end

    assign timeout_o = (IDLE_TIMEOUT != 0) && !act_o && (idle_cnt_q == IDLE_LAST);

endmodule

// File: rtl/mode_manager.sv
// Mode sequencer: HELLO until activity, then cycles modes 1..NUM_MODES-1 with a display blank window.
// mode/en/mode_chg change one cycle after the triggering input; disp/led lag mode by one cycle; no backpressure.
module mode_manager
    import mode_manager_pkg::*;
#(
    parameter int                NUM_MODES    = 4,
    parameter int                NUM_SW       = 7,
    parameter int                NUM_BTN      = 4,
    parameter int                DISP_W       = 20,
    parameter int                LED_W        = 8,
    parameter int                IDLE_TIMEOUT = 2**26,
    parameter int                BLANK_CYCLES = 4,
    parameter logic [DISP_W-1:0] BLANK_CODE   = '1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_SW-1:0]             sw_i,
    input  logic [NUM_BTN-1:0]            btn_i,
    input  logic                          mode_btn_i,
    input  logic [NUM_MODES*DISP_W-1:0]   disp_in_i,
    input  logic [NUM_MODES*LED_W-1:0]    led_in_i,
    output logic [clog2(NUM_MODES)-1:0]   mode_o,
    output logic [NUM_MODES-1:0]          en_o,
    output logic                          mode_chg_o,
    output logic [DISP_W-1:0]             disp_o,
    output logic [LED_W-1:0]              led_o
);

    localparam int MODE_W  = clog2(NUM_MODES);
    localparam int BLANK_W = clog2(BLANK_CYCLES);
    localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(NUM_MODES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

    state_e               state_q, state_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [NUM_MODES-1:0] en_q, en_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic                 mode_chg_q, mode_chg_d;
    logic [DISP_W-1:0]    disp_q, disp_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic                 act, mode_edge, timeout;

    logic [DISP_W-1:0] disp_src [NUM_MODES];
    logic [LED_W-1:0]  led_src  [NUM_MODES];

    for (genvar g = 0; g < NUM_MODES; g++) begin : g_src
        assign disp_src[g] = disp_in_i[g*DISP_W +: DISP_W];
        assign led_src[g]  = led_in_i[g*LED_W +: LED_W];
    end

    mode_manager_activity_detect #(
        .NUM_SW       (NUM_SW),
        .NUM_BTN      (NUM_BTN),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_activity_detect (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sw_i        (sw_i),
        .btn_i       (btn_i),
        .mode_btn_i  (mode_btn_i),
        .hold_i      (state_q == HELLO),
        .act_o       (act),
        .mode_edge_o (mode_edge),
        .timeout_o   (timeout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= HELLO;
            mode_q      <= '0;
            en_q        <= NUM_MODES'(1);
            blank_cnt_q <= '0;
            mode_chg_q  <= 1'b0;
            disp_q      <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            blank_cnt_q <= blank_cnt_d;
            mode_chg_q  <= mode_chg_d;
            disp_q      <= disp_d;
            led_q       <= led_d;
        end
    end

    // Timeout is already suppressed by act inside the detector, so act always wins.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        blank_cnt_d = blank_cnt_q;
        mode_chg_d  = 1'b0;
        case (state_q)
            HELLO: begin
                if (act) begin
                    state_d     = BLANK;
                    mode_d      = MODE_W'(1);
                    blank_cnt_d = '0;
                    mode_chg_d  = 1'b1;
                end
            end
            BLANK: begin
                if (timeout) begin
                    state_d     = HELLO;
                    mode_d      = '0;
                    blank_cnt_d = '0;
                    mode_chg_d  = 1'b1;
                end else if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = ACTIVE;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                end
            end
            ACTIVE: begin
                if (timeout) begin
                    state_d     = HELLO;
                    mode_d      = '0;
                    blank_cnt_d = '0;
                    mode_chg_d  = 1'b1;
                end else if (mode_edge) begin
                    state_d     = BLANK;
                    mode_d      = (mode_q == MODE_LAST) ? MODE_W'(1) : mode_q + MODE_W'(1);
                    blank_cnt_d = '0;
                    mode_chg_d  = 1'b1;
                end
            end
            default: begin
                state_d     = HELLO;
                mode_d      = '0;
                blank_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        en_d         = '0;
        en_d[mode_d] = 1'b1;
        disp_d       = (state_d == BLANK) ? BLANK_CODE : disp_src[mode_q];
        led_d        = led_src[mode_q];
    end

    assign mode_o     = mode_q;
    assign en_o       = en_q;
    assign mode_chg_o = mode_chg_q;
    assign disp_o     = disp_q;
    assign led_o      = led_q;

endmodule

// File: tb/tb_mode_manager.sv
// Directed scenarios plus randomized traffic, checked against a behavioural model of the mode rules.
module tb_mode_manager;

    localparam int NM   = 4;
    localparam int NSW  = 7;
    localparam int NBTN = 4;
    localparam int DW   = 20;
    localparam int LW   = 8;
    localparam int IT   = 16;
    localparam int BC   = 4;
    localparam logic [DW-1:0] BCODE = 20'hB1A4C;

    logic              clk = 1'b0;
    logic              rst;
    logic [NSW-1:0]    sw;
    logic [NBTN-1:0]   btn;
    logic              mode_btn;
    logic [NM*DW-1:0]  disp_in;
    logic [NM*LW-1:0]  led_in;
    logic [1:0]        mode;
    logic [NM-1:0]     en;
    logic              mode_chg;
    logic [DW-1:0]     disp;
    logic [LW-1:0]     led;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mode_manager #(
        .NUM_MODES    (NM),
        .NUM_SW       (NSW),
        .NUM_BTN      (NBTN),
        .DISP_W       (DW),
        .LED_W        (LW),
        .IDLE_TIMEOUT (IT),
        .BLANK_CYCLES (BC),
        .BLANK_CODE   (BCODE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sw_i       (sw),
        .btn_i      (btn),
        .mode_btn_i (mode_btn),
        .disp_in_i  (disp_in),
        .led_in_i   (led_in),
        .mode_o     (mode),
        .en_o       (en),
        .mode_chg_o (mode_chg),
        .disp_o     (disp),
        .led_o      (led)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] src_disp(input int m);
        return disp_in[m*DW +: DW];
    endfunction

    function automatic logic [LW-1:0] src_led(input int m);
        return led_in[m*LW +: LW];
    endfunction

    // Behavioural model: asleep flag, current mode, remaining blank cycles, cycles since last activity.
    bit              m_valid = 1'b0;
    bit              m_hello;
    int              m_mode;
    int              m_blank_left;
    int              m_idle;
    bit              e_chg;
    logic [DW-1:0]   e_disp;
    logic [LW-1:0]   e_led;
    logic [NSW-1:0]  p_sw;
    logic [NBTN-1:0] p_btn;
    logic            p_mb;

    always @(posedge clk) begin
        bit act, medge, was_hello;
        int old_mode;
        if (rst) begin
            m_valid      = 1'b1;
            m_hello      = 1'b1;
            m_mode       = 0;
            m_blank_left = 0;
            m_idle       = 0;
            e_chg        = 1'b0;
            e_disp       = '0;
            e_led        = '0;
        end else if (m_valid) begin
            medge     = mode_btn && !p_mb;
            act       = (sw != p_sw) || ((btn & ~p_btn) != 0) || medge;
            old_mode  = m_mode;
            was_hello = m_hello;
            e_chg     = 1'b0;
            if (m_hello) begin
                if (act) begin
                    m_hello = 1'b0; m_mode = 1; m_blank_left = BC; e_chg = 1'b1;
                end
            end else if (!act && m_idle == IT - 1) begin
                m_hello = 1'b1; m_mode = 0; m_blank_left = 0; e_chg = 1'b1;
            end else if (m_blank_left > 0) begin
                m_blank_left--;
            end else if (medge) begin
                m_mode = (m_mode == NM - 1) ? 1 : m_mode + 1;
                m_blank_left = BC;
                e_chg = 1'b1;
            end
            if (was_hello || act) m_idle = 0;
            else if (m_idle < IT) m_idle++;
            e_disp = (m_blank_left > 0) ? BCODE : src_disp(old_mode);
            e_led  = src_led(old_mode);
        end
        p_sw  = sw;
        p_btn = btn;
        p_mb  = mode_btn;
        #1;
        if (m_valid) begin
            chk("cmp_mode", 32'(mode), 32'(m_mode));
            chk("cmp_en", 32'(en), 32'(1) << m_mode);
            chk("cmp_chg", 32'(mode_chg), 32'(e_chg));
            chk("cmp_disp", 32'(disp), 32'(e_disp));
            chk("cmp_led", 32'(led), 32'(e_led));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; sw = '0; btn = '0; mode_btn = 1'b0;
        for (int m = 0; m < NM; m++) begin
            disp_in[m*DW +: DW] = DW'($urandom);
            led_in[m*LW +: LW]  = LW'($urandom);
        end
        tick(); tick();
        rst = 1'b0;

        // Idle in HELLO
        repeat (100) tick();
        chk("t1_mode", 32'(mode), 32'd0);
        chk("t1_en", 32'(en), 32'b0001);
        chk("t1_chg", 32'(mode_chg), 32'd0);
        chk("t1_disp", 32'(disp), 32'(src_disp(0)));
        chk("t1_led", 32'(led), 32'(src_led(0)));

        // Wake on a button edge, blank window
        btn[2] = 1'b1;
        tick();
        chk("t2_mode", 32'(mode), 32'd1);
        chk("t2_chg", 32'(mode_chg), 32'd1);
        chk("t2_en", 32'(en), 32'b0010);
        chk("t2_blank0", 32'(disp), 32'(BCODE));
        for (int i = 1; i < BC; i++) begin
            tick();
            chk("t2_blank", 32'(disp), 32'(BCODE));
        end
        chk("t2_chg_once", 32'(mode_chg), 32'd0);
        tick();
        chk("t2_disp_src", 32'(disp), 32'(src_disp(1)));
        chk("t2_led_src", 32'(led), 32'(src_led(1)));

        // Advance 1 -> 2 -> 3 -> 1 (mode 0 skipped)
        mode_btn = 1'b1; tick(); chk("t3_m2", 32'(mode), 32'd2);
        mode_btn = 1'b0; repeat (BC) tick();
        mode_btn = 1'b1; tick(); chk("t3_m3", 32'(mode), 32'd3);
        chk("t3_en3", 32'(en), 32'b1000);
        mode_btn = 1'b0; repeat (BC) tick();
        mode_btn = 1'b1; tick();
        chk("t3_wrap", 32'(mode), 32'd1);
        chk("t3_wrap_en", 32'(en), 32'b0010);
        chk("t3_wrap_chg", 32'(mode_chg), 32'd1);

        // Two mode_btn edges inside the blank window
        mode_btn = 1'b0; tick();
        mode_btn = 1'b1; tick();
        mode_btn = 1'b0; tick();
        mode_btn = 1'b1; tick();
        chk("t5_no_adv", 32'(mode), 32'd1);
        chk("t5_no_chg", 32'(mode_chg), 32'd0);
        mode_btn = 1'b0;
        k = 0;
        while (mode != 0 && k < 40) begin
            tick();
            k++;
        end
        chk("t5_idle_cycles", 32'(k), 32'd16);
        chk("t4_timeout_chg", 32'(mode_chg), 32'd1);

        // Activity late in the idle window, and in the very timeout cycle
        sw[0] = ~sw[0]; tick();
        chk("t4_wake", 32'(mode), 32'd1);
        repeat (14) tick();
        sw[0] = ~sw[0]; tick();
        repeat (15) tick();
        sw[0] = ~sw[0]; tick();
        chk("t4_act_wins", 32'(mode), 32'd1);
        chk("t4_act_wins_chg", 32'(mode_chg), 32'd0);
        k = 0;
        while (mode != 0 && k < 40) begin
            tick();
            k++;
        end
        chk("t4_idle_cycles", 32'(k), 32'd16);

        // Reset during BLANK with a changed switch
        btn[0] = 1'b1; tick();
        chk("t6_wake", 32'(mode), 32'd1);
        tick();
        rst = 1'b1; sw = sw ^ 7'h55; tick();
        chk("t6_rst_mode", 32'(mode), 32'd0);
        chk("t6_rst_en", 32'(en), 32'b0001);
        chk("t6_rst_chg", 32'(mode_chg), 32'd0);
        chk("t6_rst_disp", 32'(disp), 32'd0);
        chk("t6_rst_led", 32'(led), 32'd0);
        rst = 1'b0; tick();
        chk("t6_post_mode", 32'(mode), 32'd0);
        chk("t6_post_chg", 32'(mode_chg), 32'd0);
        repeat (3) tick();
        chk("t6_still_hello", 32'(mode), 32'd0);

        // Randomized traffic with varying activity density
        for (int blk = 0; blk < 20; blk++) begin
            int rate;
            rate = $urandom_range(0, 3);
            for (int c = 0; c < 150; c++) begin
                rst = ($urandom_range(0, 255) == 0);
                if ($urandom_range(0, 15) < rate) sw[$urandom_range(0, NSW - 1)] ^= 1'b1;
                if ($urandom_range(0, 15) < rate) btn[$urandom_range(0, NBTN - 1)] ^= 1'b1;
                if ($urandom_range(0, 3) < rate) mode_btn = ~mode_btn;
                for (int m = 0; m < NM; m++) begin
                    disp_in[m*DW +: DW] = DW'($urandom);
                    led_in[m*LW +: LW]  = LW'($urandom);
                end
                tick();
            end
        end
        rst = 1'b0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
